time_set_ctrl: RTL
==================

# time_set_ctrl

User time-setting front end for the 24-hour BCD wall clock. It debounces the MODE and UP push-buttons and runs a small edit state machine that captures the current time into a shadow register. The user steps hours and then minutes, and the block commits the result to the timekeeping counter with a one-cycle load pulse. It sits directly upstream of the timekeeping counter and also drives a digit blink mask that the seven-segment scanner consumes.

## Interface
- CLK_HZ, 100000000, system clock frequency in Hz
- DEBOUNCE_MS, 10, required stable time for a button level change
- BLINK_HZ, 2, blink rate of the digits being edited
- REPEAT_DELAY_MS, 500, hold time before auto-repeat starts (only with the macro)
- REPEAT_HZ, 8, auto-repeat rate (only with the macro)

- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high
- btn_mode  in  1  raw MODE button, active-high, asynchronous to clock
- btn_up  in  1  raw UP button, active-high, asynchronous to clock
- cur_h1, cur_h2, cur_m1, cur_m2  in  4 each  live BCD time from the timekeeping counter
- set_h1, set_h2, set_m1, set_m2  out  4 each  shadow BCD time being edited
- load_time  out  1  one-cycle pulse; the counter loads set_* and clears seconds to 00
- editing  out  1  high in SET_HOUR and SET_MIN
- blink_mask  out  6  bit order {h1,h2,m1,m2,s1,s2}; 1 means blank that digit now

## Operation
- Synchronizer: two flops per button. Debouncer: the counter restarts on any change of the synced level. The debounced level updates after DEBOUNCE_CYC = CLK_HZ/1000*DEBOUNCE_MS consecutive stable cycles. A press event is a one-cycle pulse on the debounced 0→1 edge. Releases generate no event.
- States: RUN, SET_HOUR, SET_MIN, COMMIT.
- RUN, mode event → SET_HOUR; set_* ← cur_* in that same cycle.
- SET_HOUR, mode event → SET_MIN.
- SET_MIN, mode event → COMMIT.
- COMMIT → RUN unconditionally after 1 cycle; load_time = 1 only in COMMIT.
- UP event in SET_HOUR: hours +1 BCD. 09→10, 19→20, 23→00.
- UP event in SET_MIN: minutes +1 BCD. 59→00, with no carry into hours.
- UP events in RUN and COMMIT are ignored.
- Mode and up events in the same cycle: mode wins and the up event is dropped.
- blink_mask: 6'b110000 in SET_HOUR and 6'b001100 in SET_MIN, gated by the blink phase (mask active only while phase = 1). It is 0 in RUN and COMMIT.
- Blink phase toggles every CLK_HZ/(2*BLINK_HZ) cycles. It is cleared to 0 on every entry into SET_HOUR or SET_MIN, so the edited digits are visible first.
- set_* holds its last value in RUN. The downstream counter ignores it unless load_time is high.
- Reset (any time, including mid-edit):
  - state RUN
  - set_* = 0, load_time = 0, editing = 0, blink_mask = 0
  - debounced levels 0, all counters 0
  - no load is issued

## Timing
- A raw press that is stable from cycle 0 gives a press event at cycle 2 + DEBOUNCE_CYC (±1).
- Mode event in cycle n: state changes at n+1. For SET_MIN → COMMIT, load_time is high for exactly cycle n+1 and state is RUN at n+2.
- An UP event in cycle n updates set_* at n+1.
- Glitches shorter than DEBOUNCE_CYC produce no event.
- All outputs are registered; none depend combinationally on inputs.

## Configuration
- TIME_SET_AUTOREPEAT_EN defined:
  - While UP stays debounced-high in SET_HOUR or SET_MIN, an extra up event fires after REPEAT_DELAY_MS.
  - Further events then fire every CLK_HZ/REPEAT_HZ cycles until release.
  - The repeat timer resets on release and on any state change.
- Not defined: exactly one up event per press, with no repeat logic instantiated.

## Test plan
- Bench uses CLK_HZ=1000, DEBOUNCE_MS=2 (DEBOUNCE_CYC=2), BLINK_HZ=100.
- Reset mid-SET_MIN: state returns to RUN, outputs all 0, and load_time never pulses.
- cur=23:59. Sequence: mode, up, mode, up, mode.
  - Hours 23→00, minutes 59→00.
  - One load_time pulse with set=00:00.
  - editing drops the cycle after COMMIT.
- cur=09:05, enter SET_HOUR, one UP → set_h1=1, set_h2=0 (10:05), minutes unchanged.
- btn_up bouncing 1-cycle pulses for 20 cycles, then held stable → exactly one up event.
- Mode and up debounce in the same cycle in SET_HOUR → state SET_MIN, hours unchanged.
- Blink: in SET_HOUR, blink_mask = 000000 for the first 5 cycles after entry, then 110000 for the next 5, repeating.
- With TIME_SET_AUTOREPEAT_EN: hold UP for REPEAT_DELAY_MS + 3 repeat periods in SET_MIN from 00 → minutes = 04.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Time-setting front end: button debounce, hour/minute edit FSM, load pulse and blink mask.
// Optional auto-repeat of UP while held is built when TIME_SET_AUTOREPEAT_EN is defined.
module time_set_ctrl #(
   parameter int unsigned CLK_HZ          = 100000000,
   parameter int unsigned DEBOUNCE_MS     = 10,
   parameter int unsigned BLINK_HZ        = 2,
   parameter int unsigned REPEAT_DELAY_MS = 500,
   parameter int unsigned REPEAT_HZ       = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic [3:0] cur_h1,
   input  logic [3:0] cur_h2,
   input  logic [3:0] cur_m1,
   input  logic [3:0] cur_m2,
   output logic [3:0] set_h1,
   output logic [3:0] set_h2,
   output logic [3:0] set_m1,
   output logic [3:0] set_m2,
   output logic       load_time,
   output logic       editing,
   output logic [5:0] blink_mask
);

   localparam int unsigned DebounceCyc = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int unsigned BlinkHalf   = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned DebW        = $clog2(DebounceCyc + 1);
   localparam int unsigned BlinkW      = $clog2(BlinkHalf + 1);

   if (DebounceCyc == 0 || BlinkHalf == 0 || REPEAT_HZ == 0 || REPEAT_HZ > CLK_HZ ||
       REPEAT_DELAY_MS == 0) begin : g_bad_param
      $error("time_set_ctrl: parameters give a zero-length debounce, blink or repeat period");
   end

   typedef enum logic [1:0] {StRun, StSetHour, StSetMin, StCommit} state_e;

   // Index 0 is MODE, index 1 is UP.
   logic [1:0]      sync1_q, sync2_q, deb_q, deb_d, press_q, press_d;
   logic [DebW-1:0] deb_cnt_q [2];
   logic [DebW-1:0] deb_cnt_d [2];

   state_e            state_q, state_d;
   logic [3:0]        h1_q, h2_q, m1_q, m2_q, h1_d, h2_d, m1_d, m2_d;
   logic [BlinkW-1:0] bcnt_q, bcnt_d;
   logic              phase_q, phase_d;
   logic              load_q, load_d, edit_q, edit_d;
   logic [5:0]        mask_q, mask_d;
   logic              mode_ev, up_ev;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deb_d[i]     = deb_q[i];
         deb_cnt_d[i] = '0;
         press_d[i]   = 1'b0;
         // Counter only runs while the synced level disagrees with the debounced one.
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DebW'(DebounceCyc - 1)) begin
               deb_d[i]   = sync2_q[i];
               press_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
            end
         end
      end
   end

   assign mode_ev = press_q[0];

`ifdef TIME_SET_AUTOREPEAT_EN
   localparam int unsigned RepDelay  = CLK_HZ / 1000 * REPEAT_DELAY_MS;
   localparam int unsigned RepPeriod = CLK_HZ / REPEAT_HZ;
   localparam int unsigned RepMax    = (RepDelay > RepPeriod) ? RepDelay : RepPeriod;
   localparam int unsigned RepW      = $clog2(RepMax + 1);

   logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
   logic            rep_armed_q, rep_armed_d, rep_hold, rep_fire;

   always_comb begin
      rep_hold    = deb_q[1] && (state_q == StSetHour || state_q == StSetMin);
      rep_fire    = rep_hold && (rep_armed_q ? (rep_cnt_q == RepW'(RepPeriod - 1))
                                             : (rep_cnt_q == RepW'(RepDelay - 1)));
      rep_cnt_d   = rep_cnt_q + RepW'(1);
      rep_armed_d = rep_armed_q;
      if (!rep_hold || state_d != state_q) begin
         rep_cnt_d   = '0;
         rep_armed_d = 1'b0;
      end else if (rep_fire) begin
         rep_cnt_d   = '0;
         rep_armed_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_armed_q <= rep_armed_d;
      end
   end

   assign up_ev = press_q[1] | rep_fire;
`else
   assign up_ev = press_q[1];
`endif

   always_comb begin
      state_d = state_q;
      h1_d    = h1_q;
      h2_d    = h2_q;
      m1_d    = m1_q;
      m2_d    = m2_q;
      unique case (state_q)
         StRun: begin
            if (mode_ev) begin
               state_d = StSetHour;
               {h1_d, h2_d, m1_d, m2_d} = {cur_h1, cur_h2, cur_m1, cur_m2};
            end
         end
         StSetHour: begin
            if (mode_ev) begin
               state_d = StSetMin;
            end else if (up_ev) begin
               if (h1_q == 4'd2 && h2_q == 4'd3) begin
                  {h1_d, h2_d} = 8'h00;
               end else if (h2_q == 4'd9) begin
                  h1_d = h1_q + 4'd1;
                  h2_d = 4'd0;
               end else begin
                  h2_d = h2_q + 4'd1;
               end
            end
         end
         StSetMin: begin
            if (mode_ev) begin
               state_d = StCommit;
            end else if (up_ev) begin
               if (m2_q != 4'd9) begin
                  m2_d = m2_q + 4'd1;
               end else begin
                  m2_d = 4'd0;
                  m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
               end
            end
         end
         StCommit: state_d = StRun;
         default:  state_d = StRun;
      endcase

      edit_d  = (state_d == StSetHour) || (state_d == StSetMin);
      load_d  = (state_d == StCommit);
      phase_d = phase_q;
      bcnt_d  = bcnt_q + BlinkW'(1);
      // Fresh entry into an edit state restarts blinking with digits visible.
      if (!edit_d || state_d != state_q) begin
         phase_d = 1'b0;
         bcnt_d  = '0;
      end else if (bcnt_q == BlinkW'(BlinkHalf - 1)) begin
         phase_d = ~phase_q;
         bcnt_d  = '0;
      end
      mask_d = 6'b000000;
      if (phase_d && state_d == StSetHour) mask_d = 6'b110000;
      if (phase_d && state_d == StSetMin)  mask_d = 6'b001100;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         press_q <= '0;
         for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
         state_q <= StRun;
         {h1_q, h2_q, m1_q, m2_q} <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
         load_q  <= 1'b0;
         edit_q  <= 1'b0;
         mask_q  <= '0;
      end else begin
         sync1_q <= {btn_up, btn_mode};
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         press_q <= press_d;
         for (int i = 0; i < 2; i++) deb_cnt_q[i] <= deb_cnt_d[i];
         state_q <= state_d;
         {h1_q, h2_q, m1_q, m2_q} <= {h1_d, h2_d, m1_d, m2_d};
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         load_q  <= load_d;
         edit_q  <= edit_d;
         mask_q  <= mask_d;
      end
   end

   assign set_h1     = h1_q;
   assign set_h2     = h2_q;
   assign set_m1     = m1_q;
   assign set_m2     = m2_q;
   assign load_time  = load_q;
   assign editing    = edit_q;
   assign blink_mask = mask_q;

endmodule
